led_serial_rx: RTL and testbench
================================

LED_SERIAL_RX -- requirements
Module: led_serial_rx

Interface
REQ-001 Parameter WIDTH, default 16, number of data bits per LED frame.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops per serial input (minimum 2).
REQ-003 clk  input  1  system clock; the block has one clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 led_clk  input  1  serial shift clock from the LED transmitter, asynchronous to clk.
REQ-006 led_do  input  1  serial data, sampled on led_clk rising edge, MSB first.
REQ-007 led_clr  input  1  active-low frame clear.
REQ-008 led_pen  input  1  latch strobe; its rising edge ends the frame.
REQ-009 data_out  output  WIDTH  last correctly received frame.
REQ-010 data_valid  output  1  one-clk pulse when data_out updates.
REQ-011 frame_err  output  1  one-clk pulse on a malformed frame.
REQ-012 bit_cnt  output  $clog2(WIDTH+1)  bits shifted since the last clear or latch, saturating at WIDTH.

Function
REQ-013 Each of led_clk, led_do, led_clr and led_pen SHALL pass through SYNC_STAGES flops on clk before use.
REQ-014 Rise detection SHALL compare the synchronized led_clk and led_pen against their values one clk earlier.
REQ-015 Legal input rate: led_clk high and low phases each at least 3 clk periods; led_do stable from 3 clk before to 3 clk after each led_clk rise.
REQ-016 FSM states: IDLE (bit_cnt=0), SHIFT (0<bit_cnt<WIDTH), FULL (bit_cnt=WIDTH), OVER (more than WIDTH rises seen).
REQ-017 On a synchronized led_clk rise, the shift register SHALL shift left, inserting led_do at bit 0.
REQ-018 On a synchronized led_clk rise, the FSM SHALL go IDLE->SHIFT, SHIFT->SHIFT or FULL, FULL->OVER, OVER->OVER.
REQ-019 In state OVER, the shift register SHALL keep shifting, bit_cnt SHALL hold at WIDTH, and an overrun flag SHALL be set.
REQ-020 Synchronized led_clr=0 SHALL clear the shift register, bit_cnt and the overrun flag, and SHALL set the state to IDLE.
REQ-021 Synchronized led_clr=0 takes priority over a led_clk rise in the same cycle.
REQ-022 led_pen rise in FULL SHALL load data_out from the shift register and pulse data_valid on the next clk edge.
REQ-023 led_pen rise in IDLE, SHIFT or OVER SHALL pulse frame_err, SHALL leave data_out unchanged, and SHALL not pulse data_valid.
REQ-024 Every led_pen rise SHALL return the FSM to IDLE and clear bit_cnt and the overrun flag.
REQ-025 Latency: data_valid/frame_err SHALL assert exactly SYNC_STAGES+2 clk edges after the first clk edge at which raw led_pen is sampled high.
REQ-026 Simultaneous synchronized led_clk rise and led_pen rise: the shift SHALL be applied first.
REQ-027 In that simultaneous case, the frame check and the data_out load SHALL use the post-shift register and count.
REQ-028 Simultaneous led_clr=0 and led_pen rise: the clear SHALL win, no pulse SHALL occur, and the state SHALL be IDLE.
REQ-029 data_valid and frame_err SHALL never be high in the same cycle.
REQ-030 Neither data_valid nor frame_err SHALL be high for more than one consecutive cycle per led_pen rise.

Reset
REQ-031 Reset SHALL clear all synchronizer and edge-history flops to 0.
REQ-032 Reset SHALL put data_out=0, data_valid=0, frame_err=0, bit_cnt=0 and the FSM in IDLE.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame.
REQ-034 Edges whose synchronized sample lies within the reset interval SHALL not produce a shift or latch after deassertion.

Structure
REQ-035 The FSM state encoding and the default WIDTH/SYNC_STAGES constants SHALL live in the shared package.
REQ-036 One sub-module, sync_edge, SHALL hold a SYNC_STAGES synchronizer plus rise detector.
REQ-037 sync_edge SHALL be instantiated for led_clk and led_pen.
REQ-038 led_do and led_clr SHALL use synchronizer-only instances of sync_edge, with the rise output unconnected.

Verification
REQ-039 Clear, then 16 bits MSB-first of 16'h001B (adder result 5'b11011), then led_pen -> data_out=16'h001B, one data_valid pulse, frame_err=0.
REQ-040 Clear, then 15 bits, then led_pen -> frame_err pulse, data_out retains prior 16'h001B, bit_cnt returns to 0.
REQ-041 Clear, then 17 bits, then led_pen -> frame_err pulse (OVER), no data_valid.
REQ-042 10 bits, then led_clr low, then 16 bits of 16'hA5C3, then led_pen -> data_out=16'hA5C3, data_valid pulse.
REQ-043 Reset asserted after 8 bits -> all outputs 0 and state IDLE.
REQ-044 After reset releases, 16 bits of 16'hFFFF, then led_pen -> data_out=16'hFFFF.
REQ-045 16th led_clk rise and led_pen rise in the same synchronized cycle -> shift applied, data_valid pulse with full word.

Source files
------------

// File: rtl/led_serial_rx_pkg.sv
// Shared constants and FSM encoding for the LED serial receiver.
package led_serial_rx_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // IDLE: nothing shifted, SHIFT: partial frame, FULL: exactly one frame,
  // OVER: more rises than a frame holds.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2,
    ST_OVER  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/led_serial_rx_if.sv
// Bundle of the serial LED link plus the receiver's frame outputs.
interface led_serial_rx_if
  import led_serial_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic                         led_clk;
  logic                         led_do;
  logic                         led_clr;
  logic                         led_pen;
  logic [WIDTH-1:0]             data_out;
  logic                         data_valid;
  logic                         frame_err;
  logic [$clog2(WIDTH+1)-1:0]   bit_cnt;

  // Transmitter side: drives the serial link, observes the receiver.
  modport master (
    output led_clk, led_do, led_clr, led_pen,
    input  data_out, data_valid, frame_err, bit_cnt
  );

  // Receiver side.
  modport slave (
    input  led_clk, led_do, led_clr, led_pen,
    output data_out, data_valid, frame_err, bit_cnt
  );
endinterface

// File: rtl/led_serial_rx_sync_edge.sv
// Multi-flop synchronizer with a registered rising-edge detector.
// The rise output is suppressed until the chain and the history flop hold
// real post-reset samples, so a level that was already high during reset
// never looks like a fresh edge after release.
module sync_edge
  import led_serial_rx_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES:0]   fill_q;
  logic              prev_q;
  logic              rise_q;

  // Synchronizer chain, edge history and registered rise pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q & fill_q[STAGES];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = rise_q;

endmodule

// File: rtl/led_serial_rx.sv
// Receiver for a clocked serial LED frame (shift clock, data, clear, latch).
// All link signals are resynchronized into clk; a frame is accepted only
// when the latch strobe arrives after exactly WIDTH shift clocks.
module led_serial_rx
  import led_serial_rx_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            reset,
  led_serial_rx_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic clk_rise_s, pen_rise_s, do_s, clr_n_s;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .reset(reset), .d_i(bus.led_clk), .sync_o(), .rise_o(clk_rise_s)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pen (
    .clk(clk), .reset(reset), .d_i(bus.led_pen), .sync_o(), .rise_o(pen_rise_s)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_do (
    .clk(clk), .reset(reset), .d_i(bus.led_do), .sync_o(do_s), .rise_o()
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clr (
    .clk(clk), .reset(reset), .d_i(bus.led_clr), .sync_o(clr_n_s), .rise_o()
  );

  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             over_q,  over_d;
  logic             dv_q,    dv_d;
  logic             fe_q,    fe_d;

  // State, shift register, frame output and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      over_q  <= 1'b0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      over_q  <= over_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  // Next state: clear wins; otherwise apply the shift first, then judge the
  // latch strobe against the post-shift state and count.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    over_d  = over_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    if (!clr_n_s) begin
      state_d = ST_IDLE;
      shift_d = '0;
      cnt_d   = '0;
      over_d  = 1'b0;
    end else begin
      if (clk_rise_s) begin
        shift_d = {shift_q[WIDTH-2:0], do_s};
        case (state_q)
          ST_IDLE, ST_SHIFT: begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_d == CNT_FULL) begin
              state_d = ST_FULL;
            end else begin
              state_d = ST_SHIFT;
            end
          end
          ST_FULL, ST_OVER: begin
            state_d = ST_OVER;
            over_d  = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end else begin
        shift_d = shift_q;
      end
      if (pen_rise_s) begin
        if ((state_d == ST_FULL) && !over_d) begin
          data_d = shift_d;
          dv_d   = 1'b1;
        end else begin
          fe_d   = 1'b1;
        end
        state_d = ST_IDLE;
        cnt_d   = '0;
        over_d  = 1'b0;
      end else begin
        data_d = data_q;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = dv_q;
  assign bus.frame_err  = fe_q;
  assign bus.bit_cnt    = cnt_q;

endmodule

// File: tb/tb_led_serial_rx.sv
// Directed and randomized frames checked against a bit-queue model.
module tb_led_serial_rx;

  localparam int W = 16;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;

  led_serial_rx_if #(.WIDTH(W)) bus ();

  led_serial_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: bits seen since last clear/latch, last accepted word.
  bit          model_q[$];
  logic [15:0] model_data = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_word();
    logic [15:0] w;
    int n;
    w = 16'h0000;
    n = model_q.size();
    for (int i = 0; i < 16; i++) begin
      if (model_q[n-16+i]) w = w + (16'd1 << (15 - i));
    end
    return w;
  endfunction

  function automatic int model_cnt();
    return (model_q.size() > 16) ? 16 : model_q.size();
  endfunction

  task automatic led_bit(input bit b);
    bus.led_do = b;
    wait_clk(4);
    bus.led_clk = 1'b1;
    wait_clk(4);
    bus.led_clk = 1'b0;
    wait_clk(4);
    model_q.push_back(b);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    logic [15:0] wl;
    wl = w;
    for (int i = 0; i < n; i++) begin
      if (i < 16) led_bit(wl[15-i]);
      else        led_bit(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic do_clear();
    bus.led_clr = 1'b0;
    wait_clk(6);
    bus.led_clr = 1'b1;
    wait_clk(6);
    model_q.delete();
  endtask

  // Latch strobe, optionally together with one final shift-clock rise.
  task automatic do_pen(input string tag, input bit with_bit, input bit b);
    int ndv, nfe, first, both;
    bit ok;
    ndv = 0; nfe = 0; first = 0; both = 0;
    if (with_bit) begin
      bus.led_do = b;
      wait_clk(4);
      bus.led_clk = 1'b1;
      model_q.push_back(b);
    end
    bus.led_pen = 1'b1;
    ok = (model_q.size() == 16);
    for (int k = 1; k <= 12; k++) begin
      wait_clk(1);
      if (bus.data_valid) ndv++;
      if (bus.frame_err)  nfe++;
      if (bus.data_valid && bus.frame_err) both++;
      if ((bus.data_valid || bus.frame_err) && first == 0) first = k;
    end
    bus.led_clk = 1'b0;
    wait_clk(4);
    bus.led_pen = 1'b0;
    wait_clk(6);
    if (ok) model_data = model_word();
    model_q.delete();
    chk({tag, ".dv_cnt"},  32'(ndv), ok ? 32'd1 : 32'd0);
    chk({tag, ".fe_cnt"},  32'(nfe), ok ? 32'd0 : 32'd1);
    chk({tag, ".latency"}, 32'(first), 32'(S + 2));
    chk({tag, ".both"},    32'(both), 32'd0);
    chk({tag, ".data"},    32'(bus.data_out), 32'(model_data));
    chk({tag, ".cnt0"},    32'(bus.bit_cnt), 32'd0);
  endtask

  task automatic frame(input string tag, input logic [15:0] w, input int n, input bit simul);
    do_clear();
    if (simul && n > 0) begin
      send_bits(w, n - 1);
      chk({tag, ".cnt"}, 32'(bus.bit_cnt), 32'(model_cnt()));
      do_pen(tag, 1'b1, (n - 1 < 16) ? w[16-n] : 1'b1);
    end else begin
      send_bits(w, n);
      chk({tag, ".cnt"}, 32'(bus.bit_cnt), 32'(model_cnt()));
      do_pen(tag, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int n;
    logic [15:0] w;
    bit simul;
    int ndv, nfe;
    reset = 1'b1;
    bus.led_clk = 1'b0;
    bus.led_do  = 1'b0;
    bus.led_clr = 1'b1;
    bus.led_pen = 1'b0;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(6);
    chk("rst.data", 32'(bus.data_out), 32'd0);
    chk("rst.dv",   32'(bus.data_valid), 32'd0);
    chk("rst.fe",   32'(bus.frame_err), 32'd0);
    chk("rst.cnt",  32'(bus.bit_cnt), 32'd0);

    frame("good16", 16'h001B, 16, 1'b0);
    frame("short15", 16'h1234, 15, 1'b0);
    frame("over17", 16'h5678, 17, 1'b0);

    // Partial frame discarded by a clear.
    send_bits(16'hFFC0, 10);
    chk("pre_clr.cnt", 32'(bus.bit_cnt), 32'd10);
    frame("after_clr", 16'hA5C3, 16, 1'b0);

    // Clear and latch together: no pulse of either kind.
    send_bits(16'h00FF, 16);
    bus.led_clr = 1'b0;
    bus.led_pen = 1'b1;
    ndv = 0; nfe = 0;
    for (int k = 0; k < 12; k++) begin
      wait_clk(1);
      if (bus.data_valid) ndv++;
      if (bus.frame_err)  nfe++;
    end
    bus.led_pen = 1'b0;
    wait_clk(6);
    bus.led_clr = 1'b1;
    wait_clk(6);
    model_q.delete();
    chk("clr_pen.pulses", 32'(ndv + nfe), 32'd0);
    chk("clr_pen.data", 32'(bus.data_out), 32'(model_data));
    chk("clr_pen.cnt", 32'(bus.bit_cnt), 32'd0);

    // Reset mid-frame.
    send_bits(16'h3C00, 8);
    reset = 1'b1;
    wait_clk(3);
    model_q.delete();
    model_data = 16'h0000;
    chk("rst_mid.data", 32'(bus.data_out), 32'd0);
    chk("rst_mid.dv",   32'(bus.data_valid), 32'd0);
    chk("rst_mid.fe",   32'(bus.frame_err), 32'd0);
    chk("rst_mid.cnt",  32'(bus.bit_cnt), 32'd0);
    reset = 1'b0;
    wait_clk(6);
    chk("rst_rel.cnt",  32'(bus.bit_cnt), 32'd0);
    frame("ffff", 16'hFFFF, 16, 1'b0);

    frame("simul16", 16'hC3A5, 16, 1'b1);
    frame("simul15", 16'h0F0F, 15, 1'b1);

    for (int it = 0; it < 12; it++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       n = 15;
        1:       n = 16;
        2:       n = 17;
        default: n = $urandom_range(0, 20);
      endcase
      simul = ($urandom_range(0, 2) == 0);
      frame($sformatf("rnd%0d", it), w, n, simul);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
